issue_scheduler: RTL
====================

Name: issue_scheduler

Overview:
- Sits between `decode` and the execute lanes and forms the decode→execute pipeline register.
- Takes the decoded instruction pair each cycle and decides whether it goes out together (dual issue) or one at a time (split issue).
- On a split, it issues slot0, holds slot1 internally, and stalls upstream for one cycle.
- Also handles flush, execute backpressure, and a saturating split-issue counter.

Parameters:
- CNT_W, 16, width of the saturating split-issue counter.

Ports:
- clock_i  in  1  core clock
- reset_i  in  1  synchronous, active-high reset
- inst0_i, inst1_i  in  32  slot0/slot1 instruction words from decode
- ctrl0_i, ctrl1_i  in  [`CTRL_BUS]  slot0/slot1 control bundles from decode
- pc_0_i, pc_1_i  in  32  slot PCs
- valid0_i, valid1_i  in  1  slot holds a fetched instruction
- pred_taken_0_i  in  1  slot0 predicted taken (slot1 is wrong-path)
- flush_i  in  1  squash everything (redirect or mispredict)
- exec_ready_i  in  1  execute lanes accept an issue this cycle
- inst_a_o, inst_b_o  out  32  lane A/B instruction (registered)
- ctrl_a_o, ctrl_b_o  out  [`CTRL_BUS]  lane A/B control (registered)
- pc_a_o, pc_b_o  out  32  lane A/B PC (registered)
- valid_a_o, valid_b_o  out  1  lane A/B carries a live instruction (registered)
- stall_o  out  1  decode/fetch must hold the current pair
- split_count_o  out  CNT_W  number of split issues, saturating

Behaviour:
- Reset (synchronous, active-high):
  - all registered outputs become 0
  - state becomes PAIR
  - hold register is invalidated
  - split_count_o becomes 0
  - stall_o becomes 0
- Latency: an instruction is accepted at edge N and appears on the lane outputs after edge N (one cycle).
- Effective slot1 valid: v1 = valid1_i && !(valid0_i && pred_taken_0_i). A taken-predicted slot0 drops slot1.
- Conflict (evaluated only when valid0_i && v1); any one of these causes a split:
  - RAW:
    - ctrl0_i[`REG_WRITE] is set
    - rd0 = inst0_i[11:7] is not 0
    - rd0 equals inst1_i[19:15] or inst1_i[24:20]
    - Comparison is conservative: the rs fields are compared regardless of format; a false split is legal.
  - MEM: both slots have MEM_READ or MEM_WRITE set (single memory port).
  - BR: both slots have COND_BRANCH, JAL or JALR set (single branch unit).
- State PAIR, when exec_ready_i is high and flush_i is low:
  - No conflict: lane A ← slot0, lane B ← slot1. valid_a = valid0_i, valid_b = v1. Stay in PAIR.
  - Conflict: lane A ← slot0, valid_b = 0. Hold ← slot1 (inst, ctrl, pc). split_count increments unless saturated. Go to HOLD.
  - Only v1 valid: slot1 issues in lane B, lane A is invalid. Lane order is preserved.
- State HOLD, when exec_ready_i is high and flush_i is low:
  - lane A ← hold, valid_b = 0
  - hold is invalidated
  - go to PAIR
  - The upstream pair is not consumed in this cycle.
- stall_o (combinational) = (state == HOLD) || !exec_ready_i.
  - Decode and fetch treat stall_o as "do not advance".
  - The pair that causes a conflict is consumed at the conflict edge.
- exec_ready_i low:
  - all lane outputs, the hold register and the state keep their values
  - the counter keeps its value
- flush_i high, which has priority over everything except reset:
  - valid_a/valid_b ← 0 at the next edge
  - hold is invalidated
  - state ← PAIR
  - the counter is preserved
  - stall_o in that cycle still follows its formula
  - flush_i overrides exec_ready_i low
- Counter: CNT_W bits; when it reaches all-ones it stays there.
- Invalid lanes: inst/ctrl/pc contents are don't-care; the bench checks them only when the matching valid is set.

Decomposition:
- Ctrl bit indices (`REG_WRITE`, `MEM_READ`, `MEM_WRITE`, `COND_BRANCH`, `JAL`, `JALR`), `CTRL_BUS` and the state encodings (PAIR = 0, HOLD = 1) belong in src/defs.v.
- One sub-module: pair_hazard_check, purely combinational. Inputs are both instruction words, both ctrl bundles, valid0 and v1. Outputs are conflict plus raw/mem/br flags for debug.
- The scheduler FSM, lane registers, hold register and counter stay in issue_scheduler.

Test Plan:
- Independent pair: inst0 = 0x00100293 (addi x5,x0,1), inst1 = 0x00200393 (addi x7,x0,2), both valid, exec_ready = 1 → next cycle lanes A/B = those words, both valids 1, stall_o = 0, count = 0.
- RAW split: inst0 = 0x00100293, inst1 = 0x00528333 (add x6,x5,x5) →
  - cycle+1: lane A = 0x00100293, valid_b = 0, stall_o = 1
  - cycle+2: lane A = 0x00528333, valid_b = 0, stall_o = 0
  - count = 1
- Memory split plus x0 exemption:
  - loads 0x00012083 / 0x00412183 split as in the RAW case
  - then inst0 = 0x00000013, inst1 = 0x000000b3 dual-issue (rd0 = x0, no RAW)
- Predicted taken: valid0 = valid1 = 1, pred_taken_0_i = 1 → valid_a = 1, valid_b = 0, no split, count unchanged.
- Backpressure / flush:
  - exec_ready_i low for 3 cycles mid-HOLD → outputs frozen, stall_o = 1
  - flush_i while in HOLD → next cycle both valids 0, state PAIR, held instruction never issued
  - reset_i asserted mid-HOLD → all outputs 0, count = 0
- Saturation: with CNT_W = 2, drive 5 conflicting pairs → split_count_o reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the decode-to-execute issue scheduler.
// Control-bundle bit positions, the slot payload struct and FSM encoding live here.
package issue_scheduler_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 6;

    localparam int unsigned CTRL_REG_WRITE   = 0;
    localparam int unsigned CTRL_MEM_READ    = 1;
    localparam int unsigned CTRL_MEM_WRITE   = 2;
    localparam int unsigned CTRL_COND_BRANCH = 3;
    localparam int unsigned CTRL_JAL         = 4;
    localparam int unsigned CTRL_JALR        = 5;

    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef enum logic {
        ST_PAIR = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
    } slot_t;

    function automatic logic uses_mem(input ctrl_t c);
        return c[CTRL_MEM_READ] | c[CTRL_MEM_WRITE];
    endfunction

    function automatic logic uses_branch(input ctrl_t c);
        return c[CTRL_COND_BRANCH] | c[CTRL_JAL] | c[CTRL_JALR];
    endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational structural/data hazard check between the two decoded slots.
// RAW check is conservative: rs fields are compared regardless of instruction format.
module pair_hazard_check
    import issue_scheduler_pkg::*;
(
    input  logic [XLEN-1:0] i_inst0,
    input  logic [XLEN-1:0] i_inst1,
    input  ctrl_t           i_ctrl0,
    input  ctrl_t           i_ctrl1,
    input  logic            i_valid0,
    input  logic            i_valid1_eff,
    output logic            o_conflict,
    output logic            o_raw,
    output logic            o_mem,
    output logic            o_br
);

    logic [REG_W-1:0] w_rd0;
    logic [REG_W-1:0] w_rs1_1;
    logic [REG_W-1:0] w_rs2_1;
    logic             w_both;
    logic             w_unused_fields;

    assign w_rd0   = i_inst0[11:7];
    assign w_rs1_1 = i_inst1[19:15];
    assign w_rs2_1 = i_inst1[24:20];
    assign w_both  = i_valid0 & i_valid1_eff;

    assign o_raw = w_both & i_ctrl0[CTRL_REG_WRITE] & (w_rd0 != '0)
                 & ((w_rd0 == w_rs1_1) | (w_rd0 == w_rs2_1));
    // Single memory port and single branch unit: two users cannot share a cycle.
    assign o_mem = w_both & uses_mem(i_ctrl0) & uses_mem(i_ctrl1);
    assign o_br  = w_both & uses_branch(i_ctrl0) & uses_branch(i_ctrl1);
    assign o_conflict = o_raw | o_mem | o_br;

    assign w_unused_fields = ^{i_inst0[31:12], i_inst0[6:0], i_inst1[31:25],
                               i_inst1[14:0], i_ctrl1[CTRL_REG_WRITE]};

endmodule

// File: rtl/issue_scheduler.sv
// Decode-to-execute pipeline register that dual-issues a slot pair or splits it,
// holding slot1 for one cycle; also handles flush, backpressure and a split counter.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [XLEN-1:0]  inst0_i,
    input  logic [XLEN-1:0]  inst1_i,
    input  ctrl_t            ctrl0_i,
    input  ctrl_t            ctrl1_i,
    input  logic [XLEN-1:0]  pc_0_i,
    input  logic [XLEN-1:0]  pc_1_i,
    input  logic             valid0_i,
    input  logic             valid1_i,
    input  logic             pred_taken_0_i,
    input  logic             flush_i,
    input  logic             exec_ready_i,
    output logic [XLEN-1:0]  inst_a_o,
    output logic [XLEN-1:0]  inst_b_o,
    output ctrl_t            ctrl_a_o,
    output ctrl_t            ctrl_b_o,
    output logic [XLEN-1:0]  pc_a_o,
    output logic [XLEN-1:0]  pc_b_o,
    output logic             valid_a_o,
    output logic             valid_b_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] split_count_o
);

    state_t           r_state,      w_state_nxt;
    slot_t            r_lane_a,     w_lane_a_nxt;
    slot_t            r_lane_b,     w_lane_b_nxt;
    logic             r_valid_a,    w_valid_a_nxt;
    logic             r_valid_b,    w_valid_b_nxt;
    slot_t            r_hold,       w_hold_nxt;
    logic             r_hold_valid, w_hold_valid_nxt;
    logic [CNT_W-1:0] r_count,      w_count_nxt;

    slot_t w_slot0;
    slot_t w_slot1;
    logic  w_v1;
    logic  w_conflict;
    logic  w_raw;
    logic  w_mem;
    logic  w_br;
    logic  w_unused_dbg;

    assign w_slot0 = '{inst: inst0_i, ctrl: ctrl0_i, pc: pc_0_i};
    assign w_slot1 = '{inst: inst1_i, ctrl: ctrl1_i, pc: pc_1_i};
    // A taken-predicted slot0 makes slot1 wrong-path.
    assign w_v1    = valid1_i & ~(valid0_i & pred_taken_0_i);

    pair_hazard_check u_hazard (
        .i_inst0      (inst0_i),
        .i_inst1      (inst1_i),
        .i_ctrl0      (ctrl0_i),
        .i_ctrl1      (ctrl1_i),
        .i_valid0     (valid0_i),
        .i_valid1_eff (w_v1),
        .o_conflict   (w_conflict),
        .o_raw        (w_raw),
        .o_mem        (w_mem),
        .o_br         (w_br)
    );

    assign w_unused_dbg = ^{w_raw, w_mem, w_br};

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state      <= ST_PAIR;
            r_lane_a     <= '0;
            r_lane_b     <= '0;
            r_valid_a    <= 1'b0;
            r_valid_b    <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_lane_a     <= w_lane_a_nxt;
            r_lane_b     <= w_lane_b_nxt;
            r_valid_a    <= w_valid_a_nxt;
            r_valid_b    <= w_valid_b_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_count      <= w_count_nxt;
        end
    end

    // Flush beats backpressure; backpressure freezes everything via the defaults.
    always_comb begin
        w_state_nxt      = r_state;
        w_lane_a_nxt     = r_lane_a;
        w_lane_b_nxt     = r_lane_b;
        w_valid_a_nxt    = r_valid_a;
        w_valid_b_nxt    = r_valid_b;
        w_hold_nxt       = r_hold;
        w_hold_valid_nxt = r_hold_valid;
        w_count_nxt      = r_count;
        if (flush_i) begin
            w_valid_a_nxt    = 1'b0;
            w_valid_b_nxt    = 1'b0;
            w_hold_valid_nxt = 1'b0;
            w_state_nxt      = ST_PAIR;
        end else if (exec_ready_i) begin
            case (r_state)
                ST_PAIR: begin
                    w_lane_a_nxt  = w_slot0;
                    w_valid_a_nxt = valid0_i;
                    if (w_conflict) begin
                        w_valid_b_nxt    = 1'b0;
                        w_hold_nxt       = w_slot1;
                        w_hold_valid_nxt = 1'b1;
                        w_state_nxt      = ST_HOLD;
                        if (r_count != {CNT_W{1'b1}}) begin
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                    end else begin
                        w_lane_b_nxt  = w_slot1;
                        w_valid_b_nxt = w_v1;
                    end
                end
                ST_HOLD: begin
                    w_lane_a_nxt     = r_hold;
                    w_valid_a_nxt    = r_hold_valid;
                    w_valid_b_nxt    = 1'b0;
                    w_hold_valid_nxt = 1'b0;
                    w_state_nxt      = ST_PAIR;
                end
            endcase
        end
    end

    assign inst_a_o      = r_lane_a.inst;
    assign ctrl_a_o      = r_lane_a.ctrl;
    assign pc_a_o        = r_lane_a.pc;
    assign inst_b_o      = r_lane_b.inst;
    assign ctrl_b_o      = r_lane_b.ctrl;
    assign pc_b_o        = r_lane_b.pc;
    assign valid_a_o     = r_valid_a;
    assign valid_b_o     = r_valid_b;
    assign split_count_o = r_count;
    assign stall_o       = (r_state == ST_HOLD) | ~exec_ready_i;

endmodule
